demux_1to8_reg: RTL
===================

// Module: demux_1to8_reg
// PURPOSE
//  - Registered 1-to-8 demultiplexer: the distribution counterpart of the 8:1 4-bit selector mux.
//  - Accepts one WIDTH-bit word per handshake on a single input stream and steers it to output channel S.
//  - Each of the 8 channels owns a one-entry output register with its own valid/ready handshake.
//  - Sits between a single producer and eight independent consumers; consumers stall individually.
// PARAMETERS
//  - WIDTH   4   data word width in bits
//  - CNT_W   8   width of each per-channel delivery counter (used only with DEMUX_CNT_EN)
// PORTS
//  - clk       in   1          rising-edge clock, sole clock domain
//  - rst_n     in   1          asynchronous active-low reset
//  - S         in   3          destination channel for the current input word (0..7)
//  - I         in   WIDTH      input data word
//  - i_valid   in   1          input word and S valid
//  - i_ready   out  1          block accepts the input word this cycle
//  - O         out  8*WIDTH    channel data, channel k at O[k*WIDTH +: WIDTH]
//  - o_valid   out  8          per-channel output valid
//  - o_ready   in   8          per-channel consumer ready
//  - cnt_clr   in   1          synchronous clear of all delivery counters
//  - cnt       out  8*CNT_W    per-channel delivered-word counts, channel k at cnt[k*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): o_valid=8'h00, O=0, cnt=0. i_ready is combinational, not reset.
//  - i_ready = ~o_valid[S] | o_ready[S]. It depends only on the selected channel; the other channels' state is ignored.
//  - Input transfer: i_valid & i_ready at a rising edge. Channel S register loads I; o_valid[S] becomes 1 next cycle.
//  - Latency: exactly 1 cycle from input transfer to o_valid/O visible on the channel.
//  - Output transfer: o_valid[k] & o_ready[k] at a rising edge. If channel k is not loaded in the same cycle, o_valid[k] clears to 0.
//  - Simultaneous drain and load on the same channel: the new word replaces the old one and o_valid stays 1.
//    Full throughput is 1 word/cycle to any one channel.
//  - Unselected channels hold data and valid. They drain independently and in parallel, with no cross-channel blocking.
//  - Data stability: O[k] and o_valid[k] are constant while o_valid[k]=1 & o_ready[k]=0.
//  - S and I are don't-care when i_valid=0. S is sampled only on an input transfer.
//  - A stalled channel (o_valid=1, o_ready=0) back-pressures only inputs addressed to it. i_ready=0 with S pointing there.
//  - Reset asserted mid-operation: all buffered words are discarded and counters are zeroed. No partial state survives.
//  - O data bits of an empty channel hold the last delivered word. They are not cleared on drain.
// CONFIGURATION
//  - Macro DEMUX_CNT_EN:
//    - Defined: cnt[k] increments by 1 on each output transfer of channel k and saturates at 2^CNT_W-1 (no wrap).
//    - Defined: cnt_clr=1 zeroes all counters next edge, with priority over an increment in the same cycle.
//  - Undefined: the counters are not built, cnt is tied to 0, and cnt_clr is ignored. The port list is identical in both builds.
// TESTING
//  - Reset then idle: o_valid=8'h00, O=0, i_ready=1 for every S, cnt=0.
//  - Single route: S=3'd5, I=4'hA, i_valid=1 for 1 cycle, o_ready=8'hFF.
//    -> next cycle o_valid=8'h20, O[23:20]=4'hA. Cleared the following cycle.
//  - Stall isolation: o_ready[2]=0, send 4'h1 to ch2 and then 4'h7 to ch2.
//    -> i_ready=0 on the second word while S=2. Send 4'hC to ch6: accepted, o_valid[6]=1, ch2 still holds 4'h1.
//  - Back-to-back on one channel: S=0 with I=4'h3,4'h4,4'h5 on consecutive cycles, o_ready[0]=1.
//    -> O[3:0]=3,4,5 on consecutive cycles with o_valid[0]=1 throughout and i_ready=1 throughout.
//  - Reset mid-stream: ch1 and ch7 loaded and stalled, assert rst_n=0 asynchronously.
//    -> o_valid=8'h00 immediately, before the next clock edge.
//  - DEMUX_CNT_EN with CNT_W=2: deliver 5 words on ch4 -> cnt[9:8]=2'b11 (saturated). Pulse cnt_clr -> 0.
//    Without the macro, cnt stays 0 throughout.

Source files
------------

// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demultiplexer with a one-entry valid/ready output register per channel.
// Optional per-channel saturating delivery counters are built when DEMUX_CNT_EN is defined.
module demux_1to8_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           S,
  input  logic [WIDTH-1:0]     I,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [8*WIDTH-1:0]   O,
  output logic [7:0]           o_valid,
  input  logic [7:0]           o_ready,
  input  logic                 cnt_clr,
  output logic [8*CNT_W-1:0]   cnt
);

  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       valid_q;
  logic [7:0]       load;

  // Only the addressed channel can back-pressure the producer.
  assign i_ready = ~valid_q[S] | o_ready[S];

  always_comb begin
    load = '0;
    if (i_valid && i_ready) load[S] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < 8; k++) data_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (load[k]) begin
          data_q[k]  <= I;
          valid_q[k] <= 1'b1;
        end else if (o_ready[k]) begin
          // Data is left in place on drain; only valid drops.
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign o_valid = valid_q;

  always_comb begin
    O = '0;
    for (int unsigned k = 0; k < 8; k++) O[k*WIDTH +: WIDTH] = data_q[k];
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 8; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= '0;
        end else if (valid_q[k] && o_ready[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < 8; k++) cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt = '0;
`endif

endmodule
